// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store bus controller:
//   LsuDataWidth - default width of addresses and data
//   lsu_state_e  - controller FSM state encoding (IDLE, REQ, WAIT, DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int LsuDataWidth = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no access outstanding, capturing a new request
        REQ  = 2'd1,  // bus request asserted, waiting for grant
        WAIT = 2'd2,  // load granted, waiting for the read response
        DONE = 2'd3   // completion cycle, data_valid pulses here
    } lsu_state_e;

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl_if
// Bundles the memory-stage side and the bus side of the LSU bus controller.
//
// Parameter:
//   DataWidth - width of addresses and data
//
// Memory-stage side:
//   request, we_re, mask, addr, store_data  -> controller
//   stall, data_valid, load_data, bus_err   <- controller
// Bus side:
//   mem_req, mem_we, mem_addr, mem_wdata, mem_mask <- controller
//   mem_gnt, mem_rvalid, mem_rdata                 -> controller
//
// Handshake rules:
//   - request is held high by the memory stage until data_valid pulses; the
//     access attributes are sampled only in the cycle the controller is IDLE.
//   - mem_req stays high, with stable address/data/mask, until a cycle in
//     which mem_gnt is high; that cycle is the transfer of the request.
//   - mem_rvalid is only meaningful from the cycle after a load grant; the
//     response is taken in the first such cycle with mem_rvalid high.
//   - data_valid is a single-cycle pulse; bus_err, when set, pulses with it.
//
// Modports:
//   master - the controller's view
//   slave  - the environment's view (memory stage plus bus)
// -----------------------------------------------------------------------------
interface lsu_bus_ctrl_if
    import lsu_pkg::*;
#(
    parameter int DataWidth = LsuDataWidth
);

    // memory-stage side
    logic                 request;
    logic                 we_re;
    logic [3:0]           mask;
    logic [DataWidth-1:0] addr;
    logic [DataWidth-1:0] store_data;
    logic                 stall;
    logic                 data_valid;
    logic [DataWidth-1:0] load_data;
    logic                 bus_err;

    // bus side
    logic                 mem_req;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [3:0]           mem_mask;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [DataWidth-1:0] mem_rdata;

    modport master (
        input  request, we_re, mask, addr, store_data,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall, data_valid, load_data, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport slave (
        output request, we_re, mask, addr, store_data,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall, data_valid, load_data, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

endinterface

// File: rtl/lsu_timeout_cnt.sv
// -----------------------------------------------------------------------------
// lsu_timeout_cnt
// Bus-wait cycle counter used by lsu_bus_ctrl when LSU_TIMEOUT_EN is defined.
//
// Parameter:
//   TimeoutCycles - count value at which terminal asserts
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-low reset, clears the count
//   clear    in  synchronous clear (has priority over enable)
//   enable   in  count one cycle
//   terminal out count == TimeoutCycles while enable is high
// -----------------------------------------------------------------------------
module lsu_timeout_cnt #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CntWidth = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CntWidth'(1);
        end
    end

    // Qualified with enable so a count left over from a previous access
    // cannot look like a timeout outside the waiting states.
    assign terminal = enable && (cnt == CntWidth'(TimeoutCycles));

endmodule

// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
// Load/store unit bus controller. Captures a memory-stage access, issues it
// on a simple req/gnt bus, waits for the read response on loads and reports
// completion with a one-cycle data_valid pulse.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   - a wait counter (lsu_timeout_cnt) aborts an access stuck in
//               REQ/WAIT for TimeoutCycles cycles, pulsing bus_err with
//               data_valid and returning load_data = 0.
//   undefined - no counter, bus_err is constant 0, the block waits forever.
//
// Parameters:
//   DataWidth     - address/data width
//   TimeoutCycles - bus-wait limit (only used with LSU_TIMEOUT_EN)
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset
//   bus       lsu_bus_ctrl_if.master, memory-stage and bus signals
//   dbg_state out current FSM state
// -----------------------------------------------------------------------------
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int DataWidth     = LsuDataWidth,
    parameter int TimeoutCycles = 255
) (
    input  logic               clk,
    input  logic               rst,
    lsu_bus_ctrl_if.master     bus,
    output lsu_state_e         dbg_state
);

    lsu_state_e           state;

    // access attributes captured in IDLE and frozen until the next IDLE
    logic                 cap_we;
    logic [3:0]           cap_mask;
    logic [DataWidth-1:0] cap_addr;
    logic [DataWidth-1:0] cap_wdata;

    // registered outputs
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic                 data_valid_q;
    logic                 bus_err_q;
    logic [DataWidth-1:0] load_data_q;

    // high when the wait limit is reached in REQ/WAIT
    logic                 timeout;

`ifdef LSU_TIMEOUT_EN
    logic cnt_clear;
    logic cnt_en;

    // Clear on the cycle that moves IDLE -> REQ so the count starts at 0 in
    // the first REQ cycle; count across REQ and WAIT as one budget.
    assign cnt_clear = (state == IDLE) && bus.request;
    assign cnt_en    = (state == REQ) || (state == WAIT);

    lsu_timeout_cnt #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cap_we       <= 1'b0;
            cap_mask     <= '0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            load_data_q  <= '0;
        end else begin
            // completion flags are pulses, set only on the edge into DONE
            data_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.request) begin
                        cap_we    <= bus.we_re;
                        cap_mask  <= bus.mask;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.store_data;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= bus.we_re;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    // mem_rvalid is deliberately not looked at here
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (cap_we) begin
                            data_valid_q <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        data_valid_q <= 1'b1;
                        bus_err_q    <= 1'b1;
                        load_data_q  <= '0;
                        state        <= DONE;
                    end
                end

                WAIT: begin
                    if (bus.mem_rvalid) begin
                        load_data_q  <= bus.mem_rdata;
                        data_valid_q <= 1'b1;
                        state        <= DONE;
                    end else if (timeout) begin
                        data_valid_q <= 1'b1;
                        bus_err_q    <= 1'b1;
                        load_data_q  <= '0;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    // no capture here: a waiting request is taken in IDLE
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances in the completion cycle.
    assign bus.stall      = bus.request && (state != DONE);
    assign bus.data_valid = data_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.bus_err    = bus_err_q;

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = {cap_addr[DataWidth-1:2], 2'b00};
    assign bus.mem_wdata  = cap_wdata;
    assign bus.mem_mask   = cap_mask;

    assign dbg_state      = state;

endmodule
